// File: rtl/memory_stage_if.sv
// Data-bus port bundle between the memory stage (master) and the data memory (slave).
// Request side is valid / addr_ok / data_ok; the address handshake is informational only.
interface memory_stage_if;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: issues loads/stores on the data bus, formats load data,
// stalls upstream while an access is pending. Optional MEM_PERF_CNT_EN adds access/wait counters.
module memory_stage
`ifdef MEM_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_ld,
  input  logic        in_sd,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_result,
  input  logic [63:0] in_store_data,
  input  logic [4:0]  in_dst,
  input  logic        in_regwrite,
  input  logic [63:0] in_pc,
  input  logic        in_error,
  output logic        stallm,
  memory_stage_if.master bus,
  output logic        out_valid,
  output logic [63:0] out_result,
  output logic [4:0]  out_dst,
  output logic        out_regwrite,
  output logic [63:0] out_pc,
  output logic        out_error
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_acc_cnt,
  output logic [CNT_W-1:0] perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [63:0] addr_reg, data_reg, pc_reg;
  logic [2:0]  size_reg, funct3_reg;
  logic [7:0]  strobe_reg;
  logic [4:0]  dst_reg;
  logic        regwrite_reg, ld_reg;
  logic        accept;
  logic [3:0]  nbytes;
  logic [7:0]  lane_en;
  logic [63:0] ld_shift, load_fmt;
  logic        addr_ok_unused;

  // Address acceptance carries no meaning for this stage; only data_ok ends an access.
  assign addr_ok_unused = bus.dresp_addr_ok;

  assign accept = (state_reg == IDLE) && in_valid && (in_ld || in_sd) && !in_error && !flush;
  assign nbytes = 4'd1 << in_funct3[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_en[gi] = (4'(gi) >= {1'b0, in_result[2:0]}) &&
                           (4'(gi) <  ({1'b0, in_result[2:0]} + nbytes));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // A flushed access cannot be withdrawn from the bus, so it drains to completion.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = REQ;
      REQ:     if (bus.dresp_data_ok) state_next = IDLE;
               else if (flush)        state_next = DRAIN;
      DRAIN:   if (bus.dresp_data_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stallm = 1'b0;
    case (state_reg)
      IDLE:    stallm = accept;
      REQ:     stallm = !bus.dresp_data_ok;
      default: stallm = 1'b0;
    endcase
  end

  assign ld_shift = bus.dresp_data >> {addr_reg[2:0], 3'b000};

  always_comb begin
    load_fmt = ld_shift;
    case (funct3_reg)
      3'd0:    load_fmt = {{56{ld_shift[7]}},  ld_shift[7:0]};
      3'd1:    load_fmt = {{48{ld_shift[15]}}, ld_shift[15:0]};
      3'd2:    load_fmt = {{32{ld_shift[31]}}, ld_shift[31:0]};
      3'd4:    load_fmt = {56'd0, ld_shift[7:0]};
      3'd5:    load_fmt = {48'd0, ld_shift[15:0]};
      3'd6:    load_fmt = {32'd0, ld_shift[31:0]};
      default: load_fmt = ld_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg     <= '0;
      data_reg     <= '0;
      pc_reg       <= '0;
      size_reg     <= '0;
      funct3_reg   <= '0;
      strobe_reg   <= '0;
      dst_reg      <= '0;
      regwrite_reg <= 1'b0;
      ld_reg       <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_dst      <= '0;
      out_regwrite <= 1'b0;
      out_pc       <= '0;
      out_error    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg     <= in_result;
            size_reg     <= {1'b0, in_funct3[1:0]};
            strobe_reg   <= in_ld ? 8'h00 : lane_en;
            data_reg     <= in_ld ? 64'd0 : (in_store_data << {in_result[2:0], 3'b000});
            funct3_reg   <= in_funct3;
            dst_reg      <= in_dst;
            regwrite_reg <= in_regwrite;
            pc_reg       <= in_pc;
            ld_reg       <= in_ld;
            out_valid    <= 1'b0;
          end else if (flush || !in_valid) begin
            out_valid    <= 1'b0;
          end else begin
            out_valid    <= 1'b1;
            out_result   <= in_result;
            out_dst      <= in_dst;
            out_regwrite <= in_regwrite;
            out_pc       <= in_pc;
            out_error    <= in_error;
          end
        end
        REQ: begin
          if (bus.dresp_data_ok) begin
            out_valid    <= !flush;
            out_result   <= ld_reg ? load_fmt : 64'd0;
            out_dst      <= dst_reg;
            out_regwrite <= regwrite_reg;
            out_pc       <= pc_reg;
            out_error    <= 1'b0;
          end else begin
            out_valid    <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

  assign bus.dreq_valid  = (state_reg != IDLE);
  assign bus.dreq_addr   = addr_reg;
  assign bus.dreq_size   = size_reg;
  assign bus.dreq_strobe = strobe_reg;
  assign bus.dreq_data   = data_reg;

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_acc_cnt  <= '0;
      perf_wait_cnt <= '0;
    end else begin
      if (bus.dreq_valid && bus.dresp_data_ok)  perf_acc_cnt  <= perf_acc_cnt + 1'b1;
      if (bus.dreq_valid && !bus.dresp_data_ok) perf_wait_cnt <= perf_wait_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: driver pushes expected bus requests and writeback results,
// a bus responder and a writeback monitor pop and compare independently.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ld, in_sd, in_error, in_regwrite;
  logic [2:0]  in_funct3;
  logic [63:0] in_result, in_store_data, in_pc;
  logic [4:0]  in_dst;
  logic        stallm, out_valid, out_regwrite, out_error;
  logic [63:0] out_result, out_pc;
  logic [4:0]  out_dst;

  memory_stage_if bus();

  memory_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ld(in_ld), .in_sd(in_sd),
    .in_funct3(in_funct3), .in_result(in_result), .in_store_data(in_store_data), .in_dst(in_dst),
    .in_regwrite(in_regwrite), .in_pc(in_pc), .in_error(in_error), .stallm(stallm), .bus(bus),
    .out_valid(out_valid), .out_result(out_result), .out_dst(out_dst), .out_regwrite(out_regwrite),
    .out_pc(out_pc), .out_error(out_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic        st;
  } req_t;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  dst;
    logic        rw;
    logic [63:0] pc;
    logic        err;
  } out_t;

  req_t        req_q[$];
  out_t        out_q[$];
  logic [63:0] mem [8];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Load result from first principles: pick the bytes, then wrap into the signed range if signed.
  function automatic logic [63:0] ld_model(input logic [2:0] f3, input logic [63:0] dw, input int off);
    logic [63:0] s, m, v;
    int n;
    n = 1 << f3[1:0];
    s = dw >> (8 * off);
    if (n == 8) return s;
    m = 64'd1 << (8 * n);
    v = s % m;
    if (!f3[2] && v >= (m >> 1)) v = v - m;
    return v;
  endfunction

  // fmode: 0 normal, 1 flush on presentation, 2 flush in the first request cycle
  task automatic issue(input logic ld, input logic sd, input logic [2:0] f3, input logic [63:0] res,
                       input logic [63:0] sdata, input logic err, input int fmode);
    logic mem_acc;
    logic st;
    int   n, off, cyc;
    req_t r;
    out_t o;
    mem_acc = (ld || sd) && !err;
    n   = 1 << f3[1:0];
    off = int'(res[2:0]);
    in_valid = 1'b1; in_ld = ld; in_sd = sd; in_funct3 = f3; in_result = res;
    in_store_data = sdata; in_error = err; in_dst = 5'($urandom);
    in_regwrite = 1'($urandom); in_pc = {$urandom, $urandom};
    flush = (fmode == 1);
    if (fmode == 1) begin
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      return;
    end
    if (mem_acc) begin
      r.addr   = res;
      r.size   = {1'b0, f3[1:0]};
      r.strobe = ld ? 8'h00 : 8'(((1 << n) - 1) << off);
      r.data   = sdata << (8 * off);
      r.st     = sd;
      req_q.push_back(r);
    end
    if (fmode == 0) begin
      o.dst = in_dst; o.rw = in_regwrite; o.pc = in_pc;
      if (!mem_acc) begin
        o.result = res; o.err = err;
      end else begin
        o.err = 1'b0;
        o.result = ld ? ld_model(f3, mem[res[5:3]], off) : 64'd0;
      end
      out_q.push_back(o);
      cyc = 0;
      forever begin
        @(negedge clk); #1;
        st = stallm;
        if (!mem_acc) chk("stallm_passthru", {63'd0, st}, 64'd0);
        @(posedge clk); #1;
        if (!st) break;
        cyc++;
        if (cyc > 40) begin
          chk("stall_timeout", 64'(cyc), 64'd0);
          break;
        end
      end
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      cyc = 0;
      forever begin
        @(negedge clk); #1;
        if (!bus.dreq_valid) break;
        chk("stallm_drain", {63'd0, stallm}, 64'd0);
        cyc++;
        if (cyc > 40) begin
          chk("drain_timeout", 64'(cyc), 64'd0);
          break;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Data-memory responder: checks each request against the scoreboard, answers after 0..3 waits.
  initial begin
    bit   busy;
    int   wc;
    req_t cur;
    busy = 1'b0; wc = 0;
    bus.dresp_data_ok = 1'b0; bus.dresp_addr_ok = 1'b0; bus.dresp_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0; bus.dresp_data_ok = 1'b0; bus.dresp_addr_ok = 1'b0;
        continue;
      end
      if (busy && bus.dresp_data_ok) busy = 1'b0;
      if (bus.dreq_valid && !busy) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %h, required no request", bus.dreq_addr);
          cur = '{bus.dreq_addr, bus.dreq_size, bus.dreq_strobe, bus.dreq_data, 1'b0};
        end else begin
          cur = req_q.pop_front();
        end
        busy = 1'b1;
        wc = $urandom_range(0, 3);
      end
      if (busy) begin
        chk("dreq_addr", bus.dreq_addr, cur.addr);
        chk("dreq_size", 64'(bus.dreq_size), 64'(cur.size));
        chk("dreq_strobe", 64'(bus.dreq_strobe), 64'(cur.strobe));
        if (cur.st) chk("dreq_data", bus.dreq_data, cur.data);
        if (wc == 0) begin
          bus.dresp_data_ok = 1'b1;
          bus.dresp_data = mem[bus.dreq_addr[5:3]];
        end else begin
          bus.dresp_data_ok = 1'b0;
          bus.dresp_data = {$urandom, $urandom};
          wc--;
        end
      end else begin
        bus.dresp_data_ok = ($urandom_range(0, 7) == 0);
        bus.dresp_data = {$urandom, $urandom};
      end
      bus.dresp_addr_ok = bus.dreq_valid;
    end
  end

  // Writeback monitor
  initial begin
    out_t o;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (out_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got result %h pc %h, required no output", out_result, out_pc);
        end else begin
          o = out_q.pop_front();
          chk("out_result", out_result, o.result);
          chk("out_dst", 64'(out_dst), 64'(o.dst));
          chk("out_regwrite", 64'(out_regwrite), 64'(o.rw));
          chk("out_pc", out_pc, o.pc);
          chk("out_error", 64'(out_error), 64'(o.err));
          $display("txn pc=%h result=%h dst=%0d rw=%0d err=%0d", out_pc, out_result, out_dst,
                   out_regwrite, out_error);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ld, sd, err;
    logic [2:0]  f3;
    logic [63:0] res;
    int          kind, fm, n;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ld = 1'b0; in_sd = 1'b0; in_error = 1'b0;
    in_regwrite = 1'b0; in_funct3 = '0; in_result = '0; in_store_data = '0; in_pc = '0; in_dst = '0;
    for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h0000_0000_8000_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_stallm", 64'(stallm), 64'd0);
    chk("rst_dreq_valid", 64'(bus.dreq_valid), 64'd0);
    chk("rst_dreq_strobe", 64'(bus.dreq_strobe), 64'd0);
    chk("rst_dreq_addr", bus.dreq_addr, 64'd0);
    chk("rst_dreq_data", bus.dreq_data, 64'd0);
    reset = 1'b0;

    issue(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 1'b0, 0);
    issue(1'b1, 1'b0, 3'd0, 64'h1003, 64'd0, 1'b0, 0);
    issue(1'b0, 1'b1, 3'd1, 64'h2006, 64'hBEEF, 1'b0, 0);
    issue(1'b1, 1'b0, 3'd6, 64'h8, 64'd0, 1'b1, 0);
    issue(1'b1, 1'b0, 3'd3, 64'h10, 64'd0, 1'b0, 2);
    issue(1'b1, 1'b0, 3'd3, 64'h18, 64'd0, 1'b0, 1);

    // Reset in the middle of an access
    in_valid = 1'b1; in_ld = 1'b1; in_sd = 1'b0; in_funct3 = 3'd3; in_result = 64'h20; in_error = 1'b0;
    req_q.push_back('{64'h20, 3'd3, 8'h00, 64'd0, 1'b0});
    @(posedge clk); #1;
    chk("req_before_reset", 64'(bus.dreq_valid), 64'd1);
    reset = 1'b1; in_valid = 1'b0;
    req_q.delete();
    @(posedge clk); #1;
    chk("rst_mid_dreq_valid", 64'(bus.dreq_valid), 64'd0);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_stallm", 64'(stallm), 64'd0);
    reset = 1'b0;
    issue(1'b1, 1'b0, 3'd3, 64'h28, 64'd0, 1'b0, 0);

    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 3);
      ld = (kind == 1 || kind == 2);
      sd = (kind == 3);
      f3 = ld ? 3'($urandom_range(0, 6)) : (sd ? 3'($urandom_range(0, 3)) : 3'($urandom));
      res = {$urandom, $urandom};
      n = 1 << f3[1:0];
      err = ($urandom_range(0, 15) == 0);
      if ((ld || sd) && (int'(res[2:0]) + n > 8)) err = 1'b1;
      fm = $urandom_range(0, 9);
      if (fm == 0) fm = 1;
      else if (fm == 1 && (ld || sd) && !err) fm = 2;
      else fm = 0;
      issue(ld, sd, f3, res, {$urandom, $urandom}, err, fm);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("out_q_empty", 64'(out_q.size()), 64'd0);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
